// File: rtl/message_arbiter_if.sv
// Bundle of the arbiter's data-path signals.
//   in_data    : WIDTH*N_STREAMS packed input words, stream s at [(s+1)*WIDTH-1 -: WIDTH]
//   in_nd      : per-stream one-cycle "new data" strobes
//   out_data   : registered output word
//   out_nd     : high for each cycle out_data carries a new word
//   out_stream : source stream of the current out_data word
//   error      : sticky error flag
// master drives the inputs and observes the outputs; slave is the arbiter side.
interface message_arbiter_if #(
    parameter int unsigned N_STREAMS     = 2,
    parameter int unsigned LOG_N_STREAMS = 1,
    parameter int unsigned WIDTH         = 32
) ();
    logic [WIDTH*N_STREAMS-1:0] in_data;
    logic [N_STREAMS-1:0]       in_nd;
    logic [WIDTH-1:0]           out_data;
    logic                       out_nd;
    logic [LOG_N_STREAMS-1:0]   out_stream;
    logic                       error;

    modport master (
        output in_data,
        output in_nd,
        input  out_data,
        input  out_nd,
        input  out_stream,
        input  error
    );

    modport slave (
        input  in_data,
        input  in_nd,
        output out_data,
        output out_nd,
        output out_stream,
        output error
    );
endinterface

// File: rtl/message_arbiter.sv
// Message arbiter: buffers words from N_STREAMS input streams in per-stream
// FIFOs and forwards complete messages (header + L payload words) one at a
// time onto a single output, choosing between streams round-robin.
// A header has bit WIDTH-1 set and carries the payload length in its low
// LOG_BUFFER_LENGTH bits. A message is never interleaved with another one.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : message_arbiter_if.slave (in_data, in_nd, out_data, out_nd,
//           out_stream, error)
module message_arbiter #(
    parameter int unsigned N_STREAMS         = 2,
    parameter int unsigned LOG_N_STREAMS     = 1,
    parameter int unsigned WIDTH             = 32,
    parameter int unsigned BUFFER_LENGTH     = 64,
    parameter int unsigned LOG_BUFFER_LENGTH = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    message_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = LOG_BUFFER_LENGTH + 1;
    localparam int unsigned PTR_W = LOG_BUFFER_LENGTH;
    localparam int unsigned SEL_W = LOG_N_STREAMS;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0] mem    [N_STREAMS][BUFFER_LENGTH];
    logic [PTR_W-1:0] rd_ptr [N_STREAMS];
    logic [PTR_W-1:0] wr_ptr [N_STREAMS];
    logic [CNT_W-1:0] count  [N_STREAMS];

    // Arbiter state
    state_t           state;
    logic [SEL_W-1:0] grant;
    logic [PTR_W-1:0] remaining;

    // Per-stream status and head-of-queue words
    logic [N_STREAMS-1:0] empty_c;
    logic [N_STREAMS-1:0] full_c;
    logic [N_STREAMS-1:0] push_c;
    logic [N_STREAMS-1:0] drop_c;
    logic [WIDTH-1:0]     head_c [N_STREAMS];

    always_comb begin
        for (int s = 0; s < int'(N_STREAMS); s++) begin
            empty_c[s] = (count[s] == '0);
            full_c[s]  = (count[s] == CNT_W'(BUFFER_LENGTH));
            // A full FIFO rejects the write even if it is popped this cycle.
            push_c[s]  = bus.in_nd[s] & ~full_c[s];
            drop_c[s]  = bus.in_nd[s] &  full_c[s];
            head_c[s]  = mem[s][rd_ptr[s]];
        end
    end

    // Round-robin search for the first non-empty FIFO after grant
    logic             cand_valid_c;
    logic [SEL_W-1:0] cand_c;

    always_comb begin
        logic [SEL_W-1:0] idx;
        cand_valid_c = 1'b0;
        cand_c       = '0;
        idx          = '0;
        for (int unsigned i = 1; i <= N_STREAMS; i++) begin
            idx = SEL_W'((32'(grant) + i) % N_STREAMS);
            if (!cand_valid_c && !empty_c[idx]) begin
                cand_valid_c = 1'b1;
                cand_c       = idx;
            end
        end
    end

    // Pop / forward decision for this cycle
    logic [N_STREAMS-1:0] pop_c;
    logic                 take_c;     // a word goes to the output at this edge
    logic                 bad_hdr_c;  // a non-header word found at message start
    logic [SEL_W-1:0]     sel_c;
    logic [WIDTH-1:0]     word_c;

    always_comb begin
        pop_c     = '0;
        take_c    = 1'b0;
        bad_hdr_c = 1'b0;
        sel_c     = grant;
        word_c    = head_c[grant];
        case (state)
            IDLE: begin
                if (cand_valid_c) begin
                    pop_c[cand_c] = 1'b1;
                    sel_c         = cand_c;
                    word_c        = head_c[cand_c];
                    if (word_c[WIDTH-1]) begin
                        take_c = 1'b1;
                    end else begin
                        bad_hdr_c = 1'b1;
                    end
                end
            end
            SEND: begin
                // Only the granted stream may continue; payload is not inspected.
                if (!empty_c[grant]) begin
                    pop_c[grant] = 1'b1;
                    take_c       = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // FIFO storage writes (contents need no reset)
    always_ff @(posedge clk) begin
        for (int s = 0; s < int'(N_STREAMS); s++) begin
            if (rst_n && push_c[s]) begin
                mem[s][wr_ptr[s]] <= bus.in_data[s*int'(WIDTH) +: WIDTH];
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at BUFFER_LENGTH
    always_ff @(posedge clk) begin
        for (int s = 0; s < int'(N_STREAMS); s++) begin
            if (!rst_n) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                count[s]  <= '0;
            end else begin
                if (push_c[s]) begin
                    wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
                end
                if (pop_c[s]) begin
                    rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
                end
                count[s] <= count[s] + CNT_W'(push_c[s]) - CNT_W'(pop_c[s]);
            end
        end
    end

    // Arbiter state machine with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            grant          <= SEL_W'(N_STREAMS - 1);
            remaining      <= '0;
            bus.out_nd     <= 1'b0;
            bus.out_data   <= '0;
            bus.out_stream <= '0;
            bus.error      <= 1'b0;
        end else begin
            bus.out_nd <= take_c;
            if (take_c) begin
                bus.out_data   <= word_c;
                bus.out_stream <= sel_c;
            end
            if ((|drop_c) || bad_hdr_c) begin
                bus.error <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cand_valid_c) begin
                        grant <= cand_c;
                        if (take_c) begin
                            remaining <= word_c[PTR_W-1:0];
                            // Zero-length messages complete with the header alone.
                            if (word_c[PTR_W-1:0] != '0) begin
                                state <= SEND;
                            end
                        end
                    end
                end
                SEND: begin
                    if (take_c) begin
                        remaining <= remaining - PTR_W'(1);
                        if (remaining == PTR_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_message_arbiter.sv
// Self-checking bench for message_arbiter (2 streams, 32-bit words, depth 64).
// Stimulus is scheduled per stream in queues; a queue-based model of the
// message rules predicts the output each cycle.
module tb_message_arbiter;

    localparam int unsigned NS  = 2;
    localparam int unsigned W   = 32;
    localparam int unsigned BL  = 64;

    logic clk;
    logic rst_n;

    message_arbiter_if #(.N_STREAMS(NS), .LOG_N_STREAMS(1), .WIDTH(W)) bus ();

    message_arbiter #(
        .N_STREAMS(NS), .LOG_N_STREAMS(1), .WIDTH(W),
        .BUFFER_LENGTH(BL), .LOG_BUFFER_LENGTH(6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-stream stimulus schedule: {valid, word}, one entry per cycle
    logic [32:0] sched [NS][$];

    // Reference model state
    logic [31:0] q [NS][$];
    bit          m_busy;
    int          m_grant;
    int          m_rem;
    logic        e_nd;
    logic [31:0] e_data;
    logic [0:0]  e_stream;
    logic        e_err;

    logic [34:0] got_v;
    logic [34:0] want_v;

    // Drive one cycle of scheduled stimulus, advance one edge, update the model
    task automatic tick();
        logic [NS-1:0] nd;
        logic [31:0]   d [NS];
        logic [32:0]   e;
        logic [31:0]   w;
        bit            full [NS];
        bit            r;
        int            c;
        for (int s = 0; s < int'(NS); s++) begin
            if (sched[s].size() > 0) begin
                e     = sched[s].pop_front();
                nd[s] = e[32];
                d[s]  = e[31:0];
            end else begin
                nd[s] = 1'b0;
                d[s]  = 32'h0;
            end
        end
        bus.in_nd   = nd;
        bus.in_data = {d[1], d[0]};
        r = rst_n;
        @(posedge clk);
        if (!r) begin
            for (int s = 0; s < int'(NS); s++) q[s].delete();
            m_busy = 0; m_grant = NS - 1; m_rem = 0;
            e_nd = 0; e_data = 0; e_stream = 0; e_err = 0;
        end else begin
            for (int s = 0; s < int'(NS); s++) full[s] = (q[s].size() == BL);
            e_nd = 0;
            if (m_busy) begin
                if (q[m_grant].size() != 0) begin
                    e_data = q[m_grant].pop_front();
                    e_nd = 1; e_stream = 1'(m_grant);
                    m_rem--;
                    if (m_rem == 0) m_busy = 0;
                end
            end else begin
                for (int k = 1; k <= int'(NS); k++) begin
                    c = (m_grant + k) % NS;
                    if (q[c].size() != 0) begin
                        w = q[c].pop_front();
                        m_grant = c;
                        if (w[31]) begin
                            e_nd = 1; e_data = w; e_stream = 1'(c);
                            m_rem = int'(w[5:0]);
                            m_busy = (m_rem != 0);
                        end else begin
                            e_err = 1;
                        end
                        break;
                    end
                end
            end
            for (int s = 0; s < int'(NS); s++) begin
                if (nd[s]) begin
                    if (full[s]) e_err = 1;
                    else q[s].push_back(d[s]);
                end
            end
        end
        #1;
        bus.in_nd = '0;
    endtask

    task automatic put(input int s, input logic [31:0] w);
        sched[s].push_back({1'b1, w});
    endtask

    task automatic gap(input int s, input int n);
        repeat (n) sched[s].push_back(33'h0);
    endtask

    task automatic do_reset();
        for (int s = 0; s < int'(NS); s++) sched[s].delete();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        got_v = {bus.out_nd, bus.error, bus.out_stream, bus.out_data};
        checks++;
        if (got_v !== 35'h0) begin
            errors++;
            $display("FAIL reset_values got %h want %h", got_v, 35'h0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] want_d [3];
        want_d[0] = 32'h80000002; want_d[1] = 32'h11; want_d[2] = 32'h22;
        do_reset();
        put(0, 32'h80000002); put(0, 32'h11); put(0, 32'h22);
        for (int t = 0; t < 6; t++) begin
            tick();
            got_v  = {bus.out_nd, bus.error, bus.out_nd ? bus.out_stream : 1'b0, bus.out_nd ? bus.out_data : 32'h0};
            want_v = {e_nd, e_err, e_nd ? e_stream : 1'b0, e_nd ? e_data : 32'h0};
            checks++;
            if (got_v !== want_v) begin
                errors++;
                $display("FAIL basic_model t=%0d got %h want %h", t, got_v, want_v);
            end
            // Header driven on t=0 appears after the t=1 edge
            want_v = (t >= 1 && t <= 3) ? {1'b1, 1'b0, 1'b0, want_d[t-1]} : 35'h0;
            checks++;
            if (got_v !== want_v) begin
                errors++;
                $display("FAIL basic_directed t=%0d got %h want %h", t, got_v, want_v);
            end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int p = 0; p < 2; p++) begin
            put(0, 32'h80000001); put(0, 32'hA0 + p);
            put(1, 32'h80000001); put(1, 32'hB0 + p);
        end
        for (int t = 0; t < 12; t++) begin
            tick();
            got_v  = {bus.out_nd, bus.error, bus.out_nd ? bus.out_stream : 1'b0, bus.out_nd ? bus.out_data : 32'h0};
            want_v = {e_nd, e_err, e_nd ? e_stream : 1'b0, e_nd ? e_data : 32'h0};
            checks++;
            if (got_v !== want_v) begin
                errors++;
                $display("FAIL fairness t=%0d got %h want %h", t, got_v, want_v);
            end
        end
    endtask

    task automatic test_gap();
        do_reset();
        put(0, 32'h80000003); put(0, 32'h01); gap(0, 5); put(0, 32'h02); put(0, 32'h03);
        put(1, 32'h80000002); put(1, 32'h0B); put(1, 32'h0C);
        for (int t = 0; t < 18; t++) begin
            tick();
            got_v  = {bus.out_nd, bus.error, bus.out_nd ? bus.out_stream : 1'b0, bus.out_nd ? bus.out_data : 32'h0};
            want_v = {e_nd, e_err, e_nd ? e_stream : 1'b0, e_nd ? e_data : 32'h0};
            checks++;
            if (got_v !== want_v) begin
                errors++;
                $display("FAIL gap t=%0d got %h want %h", t, got_v, want_v);
            end
        end
    endtask

    task automatic test_bad_header();
        do_reset();
        put(1, 32'h00000005); put(1, 32'h80000001); put(1, 32'h0000ABCD);
        for (int t = 0; t < 8; t++) begin
            tick();
            got_v  = {bus.out_nd, bus.error, bus.out_nd ? bus.out_stream : 1'b0, bus.out_nd ? bus.out_data : 32'h0};
            want_v = {e_nd, e_err, e_nd ? e_stream : 1'b0, e_nd ? e_data : 32'h0};
            checks++;
            if (got_v !== want_v) begin
                errors++;
                $display("FAIL bad_header t=%0d got %h want %h", t, got_v, want_v);
            end
        end
        checks++;
        if (bus.error !== 1'b1) begin
            errors++;
            $display("FAIL bad_header_sticky got %b want 1", bus.error);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        put(1, 32'h80000001);
        gap(1, 3 + 65);
        put(1, 32'h00000F00);
        gap(0, 3);
        put(0, 32'h8000003F);
        for (int i = 1; i <= 63; i++) put(0, 32'(i));
        put(0, 32'h0000DEAD);
        for (int t = 0; t < 150; t++) begin
            tick();
            got_v  = {bus.out_nd, bus.error, bus.out_nd ? bus.out_stream : 1'b0, bus.out_nd ? bus.out_data : 32'h0};
            want_v = {e_nd, e_err, e_nd ? e_stream : 1'b0, e_nd ? e_data : 32'h0};
            checks++;
            if (got_v !== want_v) begin
                errors++;
                $display("FAIL overflow t=%0d got %h want %h", t, got_v, want_v);
            end
        end
        checks++;
        if (bus.error !== 1'b1) begin
            errors++;
            $display("FAIL overflow_error got %b want 1", bus.error);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        put(0, 32'h80000004); put(0, 32'h41); put(0, 32'h42);
        for (int t = 0; t < 4; t++) begin
            tick();
            got_v  = {bus.out_nd, bus.error, bus.out_nd ? bus.out_stream : 1'b0, bus.out_nd ? bus.out_data : 32'h0};
            want_v = {e_nd, e_err, e_nd ? e_stream : 1'b0, e_nd ? e_data : 32'h0};
            checks++;
            if (got_v !== want_v) begin
                errors++;
                $display("FAIL reset_mid_pre t=%0d got %h want %h", t, got_v, want_v);
            end
        end
        // Word pushed during reset must not be stored
        rst_n = 1'b0;
        put(1, 32'h80000000);
        tick();
        rst_n = 1'b1;
        got_v = {bus.out_nd, bus.error, bus.out_stream, bus.out_data};
        checks++;
        if (got_v !== 35'h0) begin
            errors++;
            $display("FAIL reset_mid_values got %h want %h", got_v, 35'h0);
        end
        put(0, 32'h80000001); put(0, 32'h77);
        for (int t = 0; t < 5; t++) begin
            tick();
            got_v  = {bus.out_nd, bus.error, bus.out_nd ? bus.out_stream : 1'b0, bus.out_nd ? bus.out_data : 32'h0};
            want_v = {e_nd, e_err, e_nd ? e_stream : 1'b0, e_nd ? e_data : 32'h0};
            checks++;
            if (got_v !== want_v) begin
                errors++;
                $display("FAIL reset_mid_post t=%0d got %h want %h", t, got_v, want_v);
            end
            if (t == 1) begin
                checks++;
                if (got_v !== {1'b1, 1'b0, 1'b0, 32'h80000001}) begin
                    errors++;
                    $display("FAIL reset_mid_latency got %h want %h", got_v, {1'b1, 1'b0, 1'b0, 32'h80000001});
                end
            end
        end
    endtask

    task automatic test_random();
        int len;
        do_reset();
        for (int s = 0; s < int'(NS); s++) begin
            for (int m = 0; m < 10; m++) begin
                gap(s, int'($urandom_range(0, 3)));
                if ($urandom_range(0, 7) == 0) put(s, $urandom & 32'h7FFFFFFF);
                len = int'($urandom_range(0, 5));
                put(s, 32'h80000000 | 32'(len));
                for (int i = 0; i < len; i++) begin
                    gap(s, int'($urandom_range(0, 2)));
                    put(s, $urandom);
                end
            end
        end
        for (int t = 0; t < 400; t++) begin
            tick();
            got_v  = {bus.out_nd, bus.error, bus.out_nd ? bus.out_stream : 1'b0, bus.out_nd ? bus.out_data : 32'h0};
            want_v = {e_nd, e_err, e_nd ? e_stream : 1'b0, e_nd ? e_data : 32'h0};
            checks++;
            if (got_v !== want_v) begin
                errors++;
                $display("FAIL random t=%0d got %h want %h", t, got_v, want_v);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.in_nd   = '0;
        bus.in_data = '0;
        test_reset();
        test_basic();
        test_fairness();
        test_gap();
        test_bad_header();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
